// File: rtl/aes_inv_mix_seq.sv
// AES InvMixColumns, sequential: captures a 16-byte state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result until accepted.
module aes_inv_mix_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] out_state,
  output logic             busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cols
    $error("aes_inv_mix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column step wraps to 0 when all four columns are done in one cycle.
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [1:0]       col_q;
  logic [3:0][31:0] cap_q;
  logic [3:0][31:0] out_q, out_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [1:0]       col_sel;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // 0x09, 0x0B, 0x0D, 0x0E built from x*2, x*4, x*8.
  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // Column word is {a, b, c, d} with a in the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a, b, c, d;
    {a, b, c, d} = w;
    return {mule(a) ^ mulb(b) ^ muld(c) ^ mul9(d),
            mul9(a) ^ mule(b) ^ mulb(c) ^ muld(d),
            muld(a) ^ mul9(b) ^ mule(c) ^ mulb(d),
            mulb(a) ^ muld(b) ^ mul9(c) ^ mule(d)};
  endfunction

  // Next out_state: overwrite the columns handled this cycle.
  // Column i lives in packed word 3-i, i.e. index ~i.
  always_comb begin
    out_d   = out_q;
    col_sel = col_q;
    for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
      col_sel         = col_q + 2'(k);
      out_d[~col_sel] = inv_mix_col(cap_q[~col_sel]);
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= 2'd0;
      cap_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            cap_q      <= in_state;
            col_q      <= 2'd0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          out_q <= out_d;
          col_q <= col_q + ColStep;
          if (col_q == LastCol) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = out_q;

endmodule

// File: tb/tb_aes_inv_mix_seq.sv
// Bench for aes_inv_mix_seq: three instances (1, 2, 4 columns per cycle)
// checked against a GF(2^8) matrix model and known-answer vectors.
module tb_aes_inv_mix_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [15:0][7:0] in_state;
  logic             in_valid  [3];
  logic             out_ready [3];
  logic             in_ready  [3];
  logic             out_valid [3];
  logic             busy      [3];
  logic [15:0][7:0] out_state [3];

  int total = 0;
  int bad   = 0;
  int cols      [3] = '{1, 2, 4};
  int acc_cnt   [3] = '{0, 0, 0};
  int del_cnt   [3] = '{0, 0, 0};
  int exp_acc   [3] = '{0, 0, 0};
  int exp_del   [3] = '{0, 0, 0};

  aes_inv_mix_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0])
  );
  aes_inv_mix_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1])
  );
  aes_inv_mix_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2])
  );

  // Handshake counters, sampled at the clock edge where transfers happen.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && in_valid[d] && in_ready[d]) acc_cnt[d] <= acc_cnt[d] + 1;
      if (rst_n && out_valid[d] && out_ready[d]) del_cnt[d] <= del_cnt[d] + 1;
    end
  end

  // Shift-and-add GF(2^8) multiply, reduced by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant column matrix; base holds row 0 coefficients, MSB first.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] base);
    logic [7:0]   k [4];
    logic [7:0]   acc;
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) k[j] = base[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int c = 0; c < 4; c++)
          acc = acc ^ gmul(k[(c - row + 4) % 4], s[8*(15-4*i-c) +: 8]);
        r[8*(15-4*i-row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return mix(s, 32'h0e0b0d09);
  endfunction

  task automatic chk(input string name, input int d, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h exp=%h", name, d, got, exp);
    end
  endtask

  task automatic wait_out_valid(input int d, output int n);
    n = 0;
    while (!out_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full transfer: accept, check latency and result, optional stall.
  task automatic do_xfer(input int d, input logic [127:0] st, input logic [127:0] exp,
                         input int stall);
    int n;
    n = 0;
    while (!in_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      chk("in_ready_timeout", d, 128'(in_ready[d]), 128'd1);
      return;
    end
    in_state    = st;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_state    = ~st;  // later input changes must not matter
    exp_acc[d]++;
    wait_out_valid(d, n);
    chk("latency", d, 128'(n), 128'(4 / cols[d]));
    chk("result", d, out_state[d], exp);
    repeat (stall) @(negedge clk);
    if (stall > 0) chk("held_result", d, {out_state[d], 8'h0}, {exp, 8'h0} | 128'(out_valid[d] ^ 1'b1));
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    exp_del[d]++;
    chk("post_handshake", d, {126'd0, out_valid[d], in_ready[d]}, 128'b01);
  endtask

  typedef struct {
    int           d;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] V1In  = 128'h8e4da1bc_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] V1Out = 128'hdb135345_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] V2In  = 128'h9fdc589d_01010101_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] V2Out = 128'hf20a225c_01010101_d4d4d4d5_2d26314c;

  initial begin
    vec_t         tbl [6];
    logic [127:0] s1, s2, st, ref1;
    int           n, d;

    tbl[0] = '{0, V1In, V1Out};
    tbl[1] = '{0, V2In, V2Out};
    tbl[2] = '{1, V2In, V2Out};
    tbl[3] = '{2, V2In, V2Out};
    tbl[4] = '{1, V1In, V1Out};
    tbl[5] = '{2, V1In, V1Out};

    rst_n    = 1'b0;
    in_state = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_flags", i, {125'd0, in_ready[i], out_valid[i], busy[i]}, 128'd0);
      chk("reset_out", i, out_state[i], 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_after_reset", i, 128'(in_ready[i]), 128'd1);

    // Known-answer vectors.
    for (int i = 0; i < 6; i++) do_xfer(tbl[i].d, tbl[i].st, tbl[i].exp, 0);

    // Backpressure: hold DONE for 10 cycles with a second request pending.
    s1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    s2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    ref1 = inv_mix(s1);
    in_state    = s1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    exp_acc[0]++;
    in_state = s2;
    wait_out_valid(0, n);
    chk("bp_latency", 0, 128'(n), 128'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 0, {out_state[0], 6'd0, out_valid[0], in_ready[0]}, {ref1, 8'b10});
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    exp_del[0]++;
    chk("bp_idle", 0, {125'd0, in_ready[0], out_valid[0], busy[0]}, 128'b100);
    @(negedge clk);
    chk("bp_second_accept", 0, {126'd0, busy[0], in_ready[0]}, 128'b10);
    in_valid[0] = 1'b0;
    exp_acc[0]++;
    wait_out_valid(0, n);
    chk("bp_second_result", 0, out_state[0], inv_mix(s2));
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    exp_del[0]++;

    // Reset after two RUN cycles.
    in_state    = V2In;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    exp_acc[0]++;
    repeat (2) @(negedge clk);
    chk("mid_run_busy", 0, 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_flags", 0, {125'd0, in_ready[0], out_valid[0], busy[0]}, 128'd0);
    chk("mid_reset_out", 0, out_state[0], 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_ready", 0, 128'(in_ready[0]), 128'd1);
    do_xfer(0, V1In, V1Out, 0);

    // Round trip with random gaps and output stalls.
    for (int i = 0; i < 1000; i++) begin
      d  = i % 3;
      st = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_xfer(d, fwd_mix(st), st, int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("accept_count", i, 128'(acc_cnt[i]), 128'(exp_acc[i]));
      chk("deliver_count", i, 128'(del_cnt[i]), 128'(exp_del[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_mix_seq.md
Name:
aes_inv_mix_seq

Overview:
Sequential AES InvMixColumns unit for the decryption datapath. It is the inverse of the combinational forward MixColumns stage. It accepts a 16-byte state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It holds the result until the downstream stage (InvShiftRows/InvSubBytes pipeline) accepts it.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk        input   1        clock, all logic on rising edge
rst_n      input   1        synchronous reset, active-low
in_valid   input   1        in_state is valid
in_ready   output  1        block can accept a state
in_state   input   [7:0] x [15:0]  state bytes, same byte order as forward mix stage
out_valid  output  1        out_state holds a finished result
out_ready  input   1        downstream accepts out_state
out_state  output  [7:0] x [15:0]  InvMixColumns(in_state)
busy       output  1        high in state RUN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk.
- Byte mapping: column i (0..3) is a=state[15-4i], b=[14-4i], c=[13-4i], d=[12-4i].
- Per column, in GF(2^8) with reduction polynomial 0x11B:
  - out[15-4i] = 0E·a ^ 0B·b ^ 0D·c ^ 09·d
  - out[14-4i] = 09·a ^ 0E·b ^ 0B·c ^ 0D·d
  - out[13-4i] = 0D·a ^ 09·b ^ 0E·c ^ 0B·d
  - out[12-4i] = 0B·a ^ 0D·b ^ 09·c ^ 0E·d
  - Multiplies are built from xtime chains. No lookup tables.
- Registers:
  - in-state capture register, 128b.
  - out-state register, 128b, updated column by column.
  - column counter, 2b.
  - FSM.
- FSM states:
  - IDLE:
    - in_ready=1.
    - in_valid&in_ready on an edge: capture in_state, col=0, go to RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Each edge writes columns col..col+COLS_PER_CYCLE-1 of out_state and advances col by COLS_PER_CYCLE.
    - Column 3 written: go to DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_state stable while out_valid=1.
    - out_ready=1 on an edge: go to IDLE, out_valid=0.
- Latency: accept edge T; out_valid is high after edge T+4/COLS_PER_CYCLE. COLS=1 → 4 cycles, COLS=2 → 2, COLS=4 → 1.
- Throughput: the earliest next accept is the edge after the out_ready handshake. No accept overlaps DONE→IDLE.
- in_state changes after acceptance: no effect, because the input is captured.
- out_ready asserted outside DONE: ignored.
- in_valid while in_ready=0: ignored; the upstream holds it.
- Reset (rst_n=0 at an edge), in any state including mid-RUN or DONE:
  - FSM→IDLE, col=0, out_valid=0, busy=0, out_state=all 0x00, capture register cleared.
  - in_ready=1 from the first edge with rst_n=1 onward, and is low while in reset.
- Reset values of outputs: in_ready=0 during reset, 1 after; out_valid=0; busy=0; out_state=0.

Test Plan:
- Vector 1, COLS=1: in_state[15:12]=8E,4D,A1,BC, rest C6, in_valid pulse at T.
  - out_valid rises after edge T+4.
  - out[15:12]=DB,13,53,45.
  - Other columns = C6.
- Vector 2: columns 0..3 = 9F DC 58 9D / 01 01 01 01 / D5 D5 D7 D6 / 4D 7E BD F8.
  - Required output: F2 0A 22 5C / 01 01 01 01 / D4 D4 D4 D5 / 2D 26 31 4C.
  - Repeat for COLS=2 (latency 2) and COLS=4 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid stays 1, out_state unchanged, in_ready=0.
  - A second in_valid during this time is not accepted.
  - out_ready=1: IDLE on the next edge, then the second state is accepted.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles.
  - Next edge: out_valid=0, busy=0, out_state=0.
  - After release, in_ready=1 and a fresh vector completes with the correct result.
- Round-trip: random 1000 states through the forward mix function then this block.
  - Output equals the original state every time.
  - Random in_valid/out_ready stalls; no lost or duplicated transfer.
